uart_rx_fifo: RTL

- 8N1 UART receiver with a receive FIFO. It sits between the board `uart_in` pin and the MemoryUnit's UART register window.
- Produces the `uart_rx_interrupt` pulse that the top level routes to CPU `int3`.
- The MemoryUnit pops received bytes and reads status through this block.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// The encoding is kept here so that a future transmitter can reuse it.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // 50 MHz system clock divided by 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Register-window side of the UART receiver: pop and clear requests in,
// FIFO head, status and interrupt out.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);

  logic                  rd;
  logic                  clr_err;
  logic [7:0]            q;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  frame_err;
  logic                  uart_rx_interrupt;

  modport master (
    output rd, clr_err,
    input  q, empty, full, count, overrun, frame_err, uart_rx_interrupt
  );

  modport slave (
    input  rd, clr_err,
    output q, empty, full, count, overrun, frame_err, uart_rx_interrupt
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; rdata is the stored head, forced to 0 when empty.
// A write while full is accepted only if a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  wr_en;
  logic                  rd_en;

  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd);

  // count never exceeds DEPTH, so its MSB alone marks the full condition
  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive FIFO, with sticky overrun/framing flags
// and a one-cycle interrupt pulse for each byte accepted.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uart_in,
  uart_rx_fifo_if.slave   bus
);

  localparam int                TICK_W    = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t           state;
  logic [TICK_W-1:0]   tick;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                sync1;
  logic                rxs;
  logic                stop_sample;
  logic                push;
  logic                bad_stop;
  logic                fifo_full;

  // Synchronizer idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_in;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tick <= '0;
          if (!rxs) begin
            state <= START;
          end
        end
        START: begin
          if (tick == HALF_LAST) begin
            tick    <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == BIT_LAST) begin
            tick    <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == BIT_LAST) begin
            tick  <= '0;
            state <= rxs ? IDLE : WAIT_IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        WAIT_IDLE: begin
          tick <= '0;
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_sample = (state == STOP) && (tick == BIT_LAST);
  assign push        = stop_sample && rxs;
  assign bad_stop    = stop_sample && !rxs;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (shreg),
    .rd    (bus.rd),
    .rdata (bus.q),
    .count (bus.count),
    .empty (bus.empty),
    .full  (fifo_full)
  );

  assign bus.full = fifo_full;

  // A new error event outranks a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.overrun           <= 1'b0;
      bus.frame_err         <= 1'b0;
      bus.uart_rx_interrupt <= 1'b0;
    end else begin
      bus.uart_rx_interrupt <= push && (!fifo_full || bus.rd);
      bus.overrun   <= (bus.overrun && !bus.clr_err) || (push && fifo_full && !bus.rd);
      bus.frame_err <= (bus.frame_err && !bus.clr_err) || bad_stop;
    end
  end

endmodule
